uart_tx_controller: RTL and testbench
=====================================

Name: uart_tx_controller

Overview:
- Sequencing FSM for the UART TX datapath (shift/select register plus 50-cycle bit-time counter).
- Arbitrates two byte producers onto the single TX line with round-robin fairness: req0 is the command/response path, req1 is the telemetry stream.
- Drives the datapath's load, counter-reset and bit-select controls, and consumes its Count_Reached.
- Optionally inserts idle gap bit-times between frames.

Parameters:
- FRAME_BITS, 10, bits per frame: start, 8 data LSB-first, stop. Bit-select range is 0..FRAME_BITS-1.
- GAP_BITS, 0, extra idle (mark) bit-times after each stop bit, range 0..15.
- CNT_W, 4, width of the internal bit and gap index counters.

Ports:
- clk  input  1  system clock, 5.76 MHz.
- reset_b  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a byte; held until accepted.
- req0_data  input  8  requester 0 byte.
- req0_ready  output  1  one-cycle accept pulse to requester 0.
- req1_valid  input  1  requester 1 has a byte; held until accepted.
- req1_data  input  8  requester 1 byte.
- req1_ready  output  1  one-cycle accept pulse to requester 1.
- Count_Reached  input  1  from datapath; high for one cycle when its counter equals 49.
- Data_In_sel  output  1  to datapath; loads {1, Word_To_Send, 0} into the frame register.
- Word_To_Send  output  8  to datapath; registered byte being sent.
- Counter_Reset  output  1  to datapath; holds the bit-time counter at 0.
- TX_Bit_sel  output  4  to datapath; selects the frame-register bit driven onto the line.
- busy  output  1  high whenever state is not IDLE.
- grant_id  output  1  requester whose byte is currently or most recently sent.
- frame_done  output  1  one-cycle pulse when a frame, including its gap, completes.

Behaviour:
- Reset values (reset_b low, asynchronous):
  - state IDLE.
  - Data_In_sel 0, Counter_Reset 1, TX_Bit_sel 9.
  - Word_To_Send 8'h00, both ready outputs 0, busy 0, frame_done 0.
  - grant_id 1, so req0 wins the first tie.
  - Bit and gap index counters 0.
- State IDLE:
  - Counter_Reset=1, TX_Bit_sel=9, so the line is at mark.
  - If any valid is high: grant one requester, assert its ready combinationally in the same cycle, latch its data into Word_To_Send, update grant_id, go to LOAD.
- Arbitration:
  - Only one valid high: grant that requester.
  - Both high: grant the requester that is not grant_id.
  - At most one ready is high in any cycle.
- State LOAD, exactly one cycle:
  - Data_In_sel=1, Counter_Reset=1, TX_Bit_sel=9.
  - Go to SEND with bit index 0.
- State SEND:
  - Counter_Reset=0, TX_Bit_sel=bit index.
  - On Count_Reached: if bit index is FRAME_BITS-1, go to GAP (GAP_BITS>0) or DONE (GAP_BITS=0); otherwise increment bit index.
- State GAP:
  - Counter_Reset=0, TX_Bit_sel=9.
  - Count Count_Reached pulses; after GAP_BITS pulses go to DONE.
- State DONE, one cycle:
  - frame_done=1, Counter_Reset=1, TX_Bit_sel=9.
  - Go to IDLE.
- Timing:
  - Accept occurs at cycle T; LOAD is T+1; the start bit appears on the line from T+2.
  - Each bit lasts exactly 50 cycles.
  - Ready pulses are spaced by at least 503 + 50*GAP_BITS cycles.
- Word_To_Send is stable from the LOAD cycle until the next accept.
- Count_Reached in IDLE, LOAD or DONE is ignored; it cannot occur because the counter is held at 0.
- Valid deasserted before ready: no accept; the request is dropped without error.
- A valid that arrives during a frame waits until IDLE.
- Reset mid-frame: every output returns to its reset value immediately. The datapath shares reset_b, so the line returns to 1. No ready pulse is reissued.

Test Plan:
- Reset, then req0_valid=1 with data 8'hA5 -> req0_ready pulses in the accept cycle; Data_In_sel pulses 1 cycle later; TX_Bit_sel steps 0..9 every 50 cycles; line carries 0,1,0,1,0,0,1,0,1,1; frame_done pulses 502 cycles after accept.
- Both valid held continuously, data 8'h11 and 8'h22 -> grants alternate 0,1,0,1; grant_id toggles; ready pulses 503 cycles apart; no double grant.
- Only req1 valid for 3 bytes -> req1 granted each time and req0_ready stays 0; Word_To_Send matches each byte.
- GAP_BITS=2 -> after the stop bit TX_Bit_sel stays 9 for 100 cycles; ready spacing is 603 cycles.
- reset_b low at bit index 4 -> outputs go to reset values asynchronously; after release, a pending valid is accepted normally and starts a fresh frame from the start bit.
- req0_valid pulses 1 cycle during SEND, then drops -> no accept, no extra frame, busy falls after the current frame.

Source files
------------

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: round-robin two-producer UART TX sequencer driving the shift/bit-time datapath.
module uart_tx_controller #(
  parameter int FRAME_BITS = 10,
  parameter int GAP_BITS   = 0,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic       Count_Reached,
  output logic       Data_In_sel,
  output logic [7:0] Word_To_Send,
  output logic       Counter_Reset,
  output logic [3:0] TX_Bit_sel,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_BITS - 1);
  localparam logic [3:0] MARK = 4'(FRAME_BITS - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] bit_q, bit_d, gap_q, gap_d;
  logic [7:0]       word_q, word_d;
  logic             gid_q, gid_d;
  logic             pick1, accept;

  // On a tie the requester that did not go last wins; reset_b gating keeps ready low while in reset.
  assign pick1  = req1_valid & (~req0_valid | ~gid_q);
  assign accept = (state_q == IDLE) & (req0_valid | req1_valid) & reset_b;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    word_d  = word_q;
    gid_d   = gid_q;
    if (accept) begin
      state_d = LOAD;
      word_d  = pick1 ? req1_data : req0_data;
      gid_d   = pick1;
    end
    if (state_q == LOAD) begin
      state_d = SEND;
      bit_d   = '0;
    end
    if (state_q == SEND && Count_Reached) begin
      state_d = (bit_q == LAST_BIT) ? ((GAP_BITS > 0) ? GAP : DONE) : SEND;
      bit_d   = (bit_q == LAST_BIT) ? bit_q : bit_q + CNT_W'(1);
      gap_d   = '0;
    end
    if (state_q == GAP && Count_Reached) begin
      state_d = (gap_q == LAST_GAP) ? DONE : GAP;
      gap_d   = gap_q + CNT_W'(1);
    end
    if (state_q == DONE) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      bit_q   <= '0;
      gap_q   <= '0;
      word_q  <= 8'h00;
      gid_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      gid_q   <= gid_d;
    end
  end

  assign req0_ready    = accept & ~pick1;
  assign req1_ready    = accept & pick1;
  assign Data_In_sel   = state_q == LOAD;
  assign Counter_Reset = !(state_q == SEND || state_q == GAP);
  assign TX_Bit_sel    = (state_q == SEND) ? 4'(bit_q) : MARK;
  assign Word_To_Send  = word_q;
  assign busy          = state_q != IDLE;
  assign grant_id      = gid_q;
  assign frame_done    = state_q == DONE;
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: two controllers (no gap, two-bit gap) with a datapath model, checked cycle by cycle against a timing model.
module tb_uart_tx_controller;
  logic clk, reset_b;
  logic r0v[2], r1v[2], rdy0[2], rdy1[2], cr[2], dis[2], crst[2], busy[2], gid_o[2], fd[2], line[2];
  logic [7:0] r0d[2], r1d[2], wts[2];
  logic [3:0] sel[2];
  logic got0[2], got1[2], act[2], gm[2];
  logic [7:0] wm[2];
  int t0[2], last[2];
  int cyc = 0, total = 0, bad = 0;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : u
    logic [5:0] cnt;
    logic [9:0] frm;
    uart_tx_controller #(.GAP_BITS(2 * g)) dut (
      .clk(clk), .reset_b(reset_b),
      .req0_valid(r0v[g]), .req0_data(r0d[g]), .req0_ready(rdy0[g]),
      .req1_valid(r1v[g]), .req1_data(r1d[g]), .req1_ready(rdy1[g]),
      .Count_Reached(cr[g]), .Data_In_sel(dis[g]), .Word_To_Send(wts[g]),
      .Counter_Reset(crst[g]), .TX_Bit_sel(sel[g]), .busy(busy[g]),
      .grant_id(gid_o[g]), .frame_done(fd[g])
    );
    // Datapath stand-in: mod-50 bit-time counter and frame register.
    always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
        cnt <= '0;
        frm <= '1;
      end else begin
        cnt <= (crst[g] || cnt == 6'd49) ? 6'd0 : cnt + 6'd1;
        if (dis[g]) frm <= {1'b1, wts[g], 1'b0};
      end
    end
    assign cr[g]   = cnt == 6'd49;
    assign line[g] = frm[sel[g]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: accept when idle, then everything follows from cycles elapsed since the accept.
  always @(negedge clk) begin : chk
    int rel, fin;
    logic p1, acc, bit_on;
    logic [9:0] f;
    for (int k = 0; k < 2; k++) begin
      got0[k] = rdy0[k];
      got1[k] = rdy1[k];
      if (!reset_b) begin
        act[k] = 0; gm[k] = 1; wm[k] = 0; last[k] = -1;
        check("rst_rdy", {rdy0[k], rdy1[k]}, 0);
        check("rst_sel", sel[k], 9);
        check("rst_busy", busy[k], 0);
      end else begin
        fin = 502 + 100 * k;
        p1  = r1v[k] && (!r0v[k] || !gm[k]);
        acc = !act[k] && (r0v[k] || r1v[k]);
        check("word", wts[k], wm[k]);
        check("gid", gid_o[k], gm[k]);
        check("rdy0", rdy0[k], acc && !p1);
        check("rdy1", rdy1[k], acc && p1);
        if (rdy0[k] || rdy1[k]) begin
          if (last[k] >= 0) check("spacing", (cyc - last[k]) >= fin + 1, 1);
          last[k] = cyc;
        end
        if (acc) begin
          act[k] = 1; t0[k] = cyc; wm[k] = p1 ? r1d[k] : r0d[k]; gm[k] = p1;
        end
        rel    = act[k] ? cyc - t0[k] : -1;
        bit_on = act[k] && rel >= 2 && rel < 502;
        f      = {1'b1, wm[k], 1'b0};
        check("sel", sel[k], bit_on ? (rel - 2) / 50 : 9);
        check("line", line[k], bit_on ? f[(rel - 2) / 50] : 1'b1);
        check("load", dis[k], act[k] && rel == 1);
        check("crst", crst[k], !(act[k] && rel >= 2 && rel < fin));
        check("busy", busy[k], act[k] && rel >= 1);
        check("done", fd[k], act[k] && rel == fin);
        if (act[k] && rel == fin) act[k] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_checks();
    for (int k = 0; k < 2; k++) begin
      check("r_sel", sel[k], 9);
      check("r_crst", crst[k], 1);
      check("r_load", dis[k], 0);
      check("r_word", wts[k], 0);
      check("r_rdy", {rdy0[k], rdy1[k]}, 0);
      check("r_busy", busy[k], 0);
      check("r_done", fd[k], 0);
      check("r_gid", gid_o[k], 1);
      check("r_line", line[k], 1);
    end
  endtask

  task automatic put(input int k, input bit which, input logic [7:0] d);
    int n = 0;
    if (which) begin r1d[k] = d; r1v[k] = 1; end
    else begin r0d[k] = d; r0v[k] = 1; end
    do begin tick(); n++; end while (!(which ? got1[k] : got0[k]) && n < 1500);
    check("put_to", n < 1500, 1);
    if (which) r1v[k] = 0; else r0v[k] = 0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy[k] && n < 1500) begin tick(); n++; end
    check("idle_to", n < 1500, 1);
  endtask

  initial begin
    int n, pc;
    logic pw, w;
    reset_b = 1;
    for (int k = 0; k < 2; k++) begin
      r0v[k] = 0; r1v[k] = 0; r0d[k] = 0; r1d[k] = 0;
    end
    #1 reset_b = 0;
    repeat (3) tick();
    rst_checks();
    reset_b = 1;
    put(0, 0, 8'hA5);
    n = 0;
    while (!fd[0] && n < 700) begin tick(); n++; end
    check("done_lat", cyc - last[0], 502);
    wait_idle(0);
    r0d[0] = 8'h11; r1d[0] = 8'h22; r0v[0] = 1; r1v[0] = 1;
    pw = 0; pc = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin tick(); n++; end while (!(got0[0] || got1[0]) && n < 700);
      check("both_to", n < 700, 1);
      w = got1[0];
      if (i > 0) begin
        check("alt", w, !pw);
        check("both_gap", last[0] - pc, 503);
      end
      pw = w; pc = last[0];
    end
    r0v[0] = 0; r1v[0] = 0;
    wait_idle(0);
    repeat (3) put(0, 1, 8'($urandom));
    wait_idle(0);
    put(1, 0, 8'($urandom));
    pc = last[1];
    n = 0;
    while (!fd[1] && n < 800) begin tick(); n++; end
    check("gap_done", cyc - pc, 602);
    put(1, 1, 8'($urandom));
    check("gap_space", last[1] - pc, 603);
    wait_idle(1);
    put(0, 0, 8'($urandom));
    n = 0;
    while (sel[0] != 4 && n < 400) begin tick(); n++; end
    check("bit4_to", n < 400, 1);
    r1d[0] = 8'($urandom); r1v[0] = 1;
    #2 reset_b = 0;
    #1 rst_checks();
    tick(); tick();
    reset_b = 1;
    n = 0;
    do begin tick(); n++; end while (!got1[0] && n < 5);
    check("rst_acc", got1[0], 1);
    r1v[0] = 0;
    wait_idle(0);
    put(0, 1, 8'($urandom));
    n = 0;
    while (sel[0] != 3 && n < 300) begin tick(); n++; end
    r0d[0] = 8'($urandom); r0v[0] = 1;
    tick();
    r0v[0] = 0;
    wait_idle(0);
    repeat (5) tick();
    check("no_extra", busy[0], 0);
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (got0[k] || (r0v[k] && $urandom_range(199) == 0)) r0v[k] = 0;
        else if (!r0v[k] && $urandom_range(59) == 0) begin r0v[k] = 1; r0d[k] = 8'($urandom); end
        if (got1[k] || (r1v[k] && $urandom_range(199) == 0)) r1v[k] = 0;
        else if (!r1v[k] && $urandom_range(59) == 0) begin r1v[k] = 1; r1d[k] = 8'($urandom); end
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin r0v[k] = 0; r1v[k] = 0; end
    wait_idle(0);
    wait_idle(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
